// File: rtl/vx_ibuf_pkg.sv
// Shared types and defaults for the per-warp instruction buffer.
// ibuf_data_t mirrors the decode payload field for field so a decoded
// instruction can be stored and replayed to issue without repacking.
package vx_ibuf_pkg;

    localparam int unsigned NUM_WARPS      = 4;
    localparam int unsigned NUM_THREADS    = 4;
    localparam int unsigned ISSUE_WIDTH    = 1;
    localparam int unsigned IBUF_DEPTH_DEF = 4;
    localparam int unsigned WARPS_PER_SLOT = NUM_WARPS / ISSUE_WIDTH;

    localparam int unsigned UUID_W = 44;
    localparam int unsigned NW_W   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int unsigned EX_W   = 3;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned MOD_W  = 3;
    localparam int unsigned REG_W  = 6;

    typedef struct packed {
        logic [UUID_W-1:0]      uuid;
        logic [NW_W-1:0]        wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [EX_W-1:0]        ex_type;
        logic [OP_W-1:0]        op_type;
        logic [MOD_W-1:0]       op_mod;
        logic                   wb;
        logic                   use_PC;
        logic                   use_imm;
        logic [31:0]            PC;
        logic [31:0]            imm;
        logic [REG_W-1:0]       rd;
        logic [REG_W-1:0]       rs1;
        logic [REG_W-1:0]       rs2;
        logic [REG_W-1:0]       rs3;
    } ibuf_data_t;

endpackage

// File: rtl/vx_ibuf_warp_fifo.sv
// Single-warp instruction FIFO with registered storage.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   i_push/i_data enqueue one entry (caller guarantees !o_full)
//   i_pop         dequeue head (caller guarantees !o_empty)
//   o_data        head entry; a push into an empty FIFO appears next cycle
//   o_count       occupancy 0..DEPTH
//   o_full/o_empty occupancy flags from the registered count
module vx_ibuf_warp_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [DATA_W-1:0]       i_data,
    output logic [DATA_W-1:0]       o_data,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(i_push && o_full)) else $error("ibuf fifo: push while full");
            assert (!(i_pop && o_empty)) else $error("ibuf fifo: pop while empty");
        end
    end

endmodule

// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction buffer between decode and issue.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   dec_valid/dec_data/dec_ready  decode stream; dec_data.wid picks the warp FIFO
//   dec_ibuf_pop   one-cycle pulse per slot dequeue (scheduler credit return)
//   ibuf_valid/ibuf_data/ibuf_ready  per-slot issue handshake
//   warp_empty     per-warp FIFO empty flag
// Warp w belongs to slot w % ISSUE_CNT; each slot round-robins over its warps.
module vx_warp_ibuffer
    import vx_ibuf_pkg::*;
#(
    parameter int unsigned WARP_CNT   = NUM_WARPS,
    parameter int unsigned THREAD_CNT = NUM_THREADS,
    parameter int unsigned ISSUE_CNT  = ISSUE_WIDTH,
    parameter int unsigned IBUF_DEPTH = IBUF_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          dec_valid,
    input  ibuf_data_t                    dec_data,
    output logic                          dec_ready,
    output logic       [ISSUE_CNT-1:0]    dec_ibuf_pop,
    output logic       [ISSUE_CNT-1:0]    ibuf_valid,
    output ibuf_data_t [ISSUE_CNT-1:0]    ibuf_data,
    input  logic       [ISSUE_CNT-1:0]    ibuf_ready,
    output logic       [WARP_CNT-1:0]     warp_empty
);
    localparam int unsigned WPS   = WARP_CNT / ISSUE_CNT;
    localparam int unsigned RR_W  = (WPS > 1) ? $clog2(WPS) : 1;
    localparam int unsigned WID_W = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1;
    localparam int unsigned CNT_W = $clog2(IBUF_DEPTH) + 1;

    logic [WARP_CNT-1:0] w_push;
    logic [WARP_CNT-1:0] w_pop;
    logic [WARP_CNT-1:0] w_full;
    logic [WARP_CNT-1:0] w_empty;
    logic [CNT_W-1:0]    w_count [WARP_CNT];
    ibuf_data_t          w_head  [WARP_CNT];
    logic                w_wid_ok;

    logic [ISSUE_CNT-1:0] w_slot_fire;
    logic [WID_W-1:0]     w_slot_wid [ISSUE_CNT];

    // Readiness uses only the registered full flag: a pop in the same cycle
    // does not open the FIFO, which keeps ibuf_ready off the decode path.
    assign w_wid_ok  = int'(dec_data.wid) < WARP_CNT;
    assign dec_ready = w_wid_ok && !w_full[dec_data.wid];

    always_comb begin
        w_push = '0;
        if (dec_valid && dec_ready) begin
            w_push[dec_data.wid] = 1'b1;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int unsigned s = 0; s < ISSUE_CNT; s++) begin
            if (w_slot_fire[s]) w_pop[w_slot_wid[s]] = 1'b1;
        end
    end

    for (genvar w = 0; w < WARP_CNT; w++) begin : g_warp
        vx_ibuf_warp_fifo #(
            .DEPTH  (IBUF_DEPTH),
            .DATA_W ($bits(ibuf_data_t))
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[w]),
            .i_pop   (w_pop[w]),
            .i_data  (dec_data),
            .o_data  (w_head[w]),
            .o_count (w_count[w]),
            .o_full  (w_full[w]),
            .o_empty (w_empty[w])
        );
    end

    assign warp_empty = w_empty;

    for (genvar s = 0; s < ISSUE_CNT; s++) begin : g_slot
        logic [RR_W-1:0] r_rr_ptr;
        logic [RR_W-1:0] r_lock_idx;
        logic            r_locked;
        logic [RR_W-1:0] w_pick_idx;
        logic [RR_W-1:0] w_sel_idx;
        logic            w_any;
        logic            w_valid;

        always_comb begin : p_pick
            int unsigned idx;
            idx        = 0;
            w_any      = 1'b0;
            w_pick_idx = '0;
            for (int unsigned k = 0; k < WPS; k++) begin
                idx = (32'(r_rr_ptr) + k) % WPS;
                if (!w_any && (w_count[WID_W'(32'(s) + idx * ISSUE_CNT)] != '0)) begin
                    w_any      = 1'b1;
                    w_pick_idx = RR_W'(idx);
                end
            end
        end

        // A stalled head stays locked to its warp: otherwise a push to an
        // empty warp earlier in RR order would re-select under back-pressure.
        // The locked warp cannot drain while locked, so it stays non-empty.
        assign w_sel_idx      = r_locked ? r_lock_idx : w_pick_idx;
        assign w_valid        = (r_locked || w_any) && !reset;
        assign w_slot_wid[s]  = WID_W'(32'(s) + 32'(w_sel_idx) * ISSUE_CNT);
        assign w_slot_fire[s] = w_valid && ibuf_ready[s];

        assign ibuf_valid[s]   = w_valid;
        assign ibuf_data[s]    = w_head[w_slot_wid[s]];
        assign dec_ibuf_pop[s] = w_slot_fire[s];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_rr_ptr   <= '0;
                r_locked   <= 1'b0;
                r_lock_idx <= '0;
            end else begin
                r_locked   <= w_valid && !ibuf_ready[s];
                r_lock_idx <= w_sel_idx;
                if (w_slot_fire[s]) begin
                    r_rr_ptr <= (w_sel_idx == RR_W'(WPS - 1)) ? '0 : w_sel_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($bits(dec_data.tmask) == THREAD_CNT) else $error("ibuf: tmask width differs from THREAD_CNT");
            if (dec_valid) begin
                assert (w_wid_ok) else $error("ibuf: dec_data.wid out of range");
            end
            assert ((w_push & w_full) == '0) else $error("ibuf: push to full warp");
        end
    end

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
module tb_vx_warp_ibuffer;
    import vx_ibuf_pkg::*;

    localparam int TB_WARPS = 4;
    localparam int TB_ISSUE = 1;
    localparam int TB_DEPTH = 4;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        dec_valid;
    ibuf_data_t                  dec_data;
    logic                        dec_ready;
    logic       [TB_ISSUE-1:0]   dec_ibuf_pop;
    logic       [TB_ISSUE-1:0]   ibuf_valid;
    ibuf_data_t [TB_ISSUE-1:0]   ibuf_data;
    logic       [TB_ISSUE-1:0]   ibuf_ready;
    logic       [TB_WARPS-1:0]   warp_empty;

    vx_warp_ibuffer #(
        .WARP_CNT   (TB_WARPS),
        .THREAD_CNT (NUM_THREADS),
        .ISSUE_CNT  (TB_ISSUE),
        .IBUF_DEPTH (TB_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dec_valid    (dec_valid),
        .dec_data     (dec_data),
        .dec_ready    (dec_ready),
        .dec_ibuf_pop (dec_ibuf_pop),
        .ibuf_valid   (ibuf_valid),
        .ibuf_data    (ibuf_data),
        .ibuf_ready   (ibuf_ready),
        .warp_empty   (warp_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ibuf_data_t mk(input int w, input logic [31:0] pc);
        ibuf_data_t d;
        d.uuid    = UUID_W'({$urandom, $urandom});
        d.wid     = NW_W'(w);
        d.tmask   = NUM_THREADS'($urandom);
        d.ex_type = EX_W'($urandom);
        d.op_type = OP_W'($urandom);
        d.op_mod  = MOD_W'($urandom);
        d.wb      = 1'($urandom);
        d.use_PC  = 1'($urandom);
        d.use_imm = 1'($urandom);
        d.PC      = pc;
        d.imm     = $urandom;
        d.rd      = REG_W'($urandom);
        d.rs1     = REG_W'($urandom);
        d.rs2     = REG_W'($urandom);
        d.rs3     = REG_W'($urandom);
        return d;
    endfunction

    // Reference model: one queue of pending instructions per warp. The slot
    // offers the first non-empty warp after the last one issued (cyclic); a
    // warp that has been offered keeps being offered until it is taken.
    ibuf_data_t mq [TB_WARPS][$];
    int         last_next = 0;
    int         offered   = -1;
    bit         mon_en    = 0;
    int         pulse_cnt = 0;
    int         issued_q [$];

    always @(negedge clk) begin
        int               sel;
        bit               any;
        bit               exp_valid;
        bit               exp_ready;
        logic [TB_WARPS-1:0] exp_empty;
        if (mon_en) begin
            any = 0;
            for (int w = 0; w < TB_WARPS; w++) begin
                exp_empty[w] = (mq[w].size() == 0);
                if (mq[w].size() != 0) any = 1;
            end
            exp_ready = (mq[dec_data.wid].size() < TB_DEPTH);
            sel = -1;
            if (offered >= 0) sel = offered;
            else begin
                for (int k = 0; k < TB_WARPS; k++) begin
                    int w;
                    w = (last_next + k) % TB_WARPS;
                    if (sel < 0 && mq[w].size() != 0) sel = w;
                end
            end
            exp_valid = any && !reset;

            check("warp_empty", warp_empty, exp_empty);
            check("dec_ready", dec_ready, exp_ready);
            check("ibuf_valid", ibuf_valid[0], exp_valid);
            check("dec_ibuf_pop", dec_ibuf_pop[0], exp_valid && ibuf_ready[0]);
            if (exp_valid) check("ibuf_data", ibuf_data[0], mq[sel][0]);
            if (dec_ibuf_pop[0]) pulse_cnt++;

            if (reset) begin
                for (int w = 0; w < TB_WARPS; w++) mq[w].delete();
                last_next = 0;
                offered   = -1;
            end else begin
                if (exp_valid && ibuf_ready[0]) begin
                    issued_q.push_back(int'(ibuf_data[0].wid));
                    void'(mq[sel].pop_front());
                    last_next = (sel + 1) % TB_WARPS;
                    offered   = -1;
                end else if (exp_valid) begin
                    offered = sel;
                end
                if (dec_valid && exp_ready) mq[dec_data.wid].push_back(dec_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int w, input logic [31:0] pc, input bit rdy);
        dec_valid     = v;
        dec_data      = mk(w, pc);
        ibuf_ready[0] = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    int p0;
    int q0;
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0);
        repeat (2) tick();
        mon_en = 1'b1;
        tick();
        reset = 1'b0;

        // idle after reset
        p0 = pulse_cnt;
        repeat (10) tick();
        check("idle_pop_pulses", 32'(pulse_cnt - p0), 0);

        // single push, immediate issue
        p0 = pulse_cnt;
        q0 = issued_q.size();
        drive(1, 0, 32'h8000_0000, 1);
        tick();
        drive(0, 0, 0, 1);
        repeat (3) tick();
        check("single_pop_pulses", 32'(pulse_cnt - p0), 1);
        check("single_issued_cnt", 32'(issued_q.size() - q0), 1);

        // fill warp 1, then one-cycle drain with push still pending
        do_reset();
        for (int i = 0; i < TB_DEPTH; i++) begin
            drive(1, 1, 32'h100 + 32'(4 * i), 0);
            tick();
        end
        drive(1, 1, 32'h200, 0);
        @(negedge clk);
        check("fill_full_ready", dec_ready, 0);
        tick();
        ibuf_ready[0] = 1'b1;
        @(negedge clk);
        check("full_ready_during_pop", dec_ready, 0);
        tick();
        ibuf_ready[0] = 1'b0;
        @(negedge clk);
        check("ready_after_pop", dec_ready, 1);
        tick();
        drive(0, 0, 0, 1);
        repeat (8) tick();

        // round-robin order across four warps
        do_reset();
        q0 = issued_q.size();
        for (int w = 0; w < TB_WARPS; w++) begin
            for (int j = 0; j < 2; j++) begin
                drive(1, w, 32'h1000 * 32'(w) + 32'(j), 0);
                tick();
            end
        end
        drive(0, 0, 0, 1);
        repeat (10) tick();
        check("rr_issued_cnt", 32'(issued_q.size() - q0), 8);
        for (int i = 0; i < 8; i++) begin
            if (q0 + i < issued_q.size()) check("rr_order", 32'(issued_q[q0 + i]), 32'(exp_order[i]));
        end

        // back-pressure: warp 1 held while lower/other warps fill
        do_reset();
        q0 = issued_q.size();
        drive(1, 1, 32'h4000, 0);
        tick();
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            drive(1, (i % 3 == 1) ? 2 : ((i % 3 == 2) ? 3 : 0), 32'h5000 + 32'(i), 0);
            tick();
        end
        check("bp_pop_pulses", 32'(pulse_cnt - p0), 0);
        drive(0, 0, 0, 1);
        repeat (8) tick();
        if (issued_q.size() > q0) check("bp_first_wid", 32'(issued_q[q0]), 1);
        else check("bp_first_wid_missing", 32'(issued_q.size() - q0), 1);

        // reset with entries buffered
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 2, 32'h6000 + 32'(i), 0);
            tick();
        end
        p0 = pulse_cnt;
        q0 = issued_q.size();
        do_reset();
        drive(0, 0, 0, 1);
        repeat (5) tick();
        check("rst_pop_pulses", 32'(pulse_cnt - p0), 0);
        check("rst_issued_cnt", 32'(issued_q.size() - q0), 0);
        check("rst_warp_empty", warp_empty, 4'hF);

        // randomized traffic with varying back-pressure and occasional reset
        for (int blk = 0; blk < 8; blk++) begin
            int rdy_pct;
            rdy_pct = 20 + 10 * blk;
            for (int c = 0; c < 200; c++) begin
                drive(($urandom % 3) != 0, int'($urandom % TB_WARPS), $urandom,
                      int'($urandom % 100) < rdy_pct);
                reset = (($urandom % 250) == 0);
                tick();
            end
        end
        reset = 1'b0;
        drive(0, 0, 0, 1);
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
